// File: rtl/mig_pkg.sv
// Shared definitions for the MIG command arbiter: FSM encoding, command word layout, default widths.
package mig_pkg;

  localparam int unsigned ADRW_DEF  = 28;
  localparam int unsigned DW_DEF    = 128;
  localparam int unsigned LEN_W     = 2;
  localparam int unsigned CMD_HDR_W = 4;

  // Command word is {id, wr, len, adr}; these offsets sit above the ADRW-bit address field.
  localparam int unsigned CMD_LEN_OFS = 0;
  localparam int unsigned CMD_WR_OFS  = 2;
  localparam int unsigned CMD_ID_OFS  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WDAT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mig_rr_pick.sv
// Two-input winner select for the MIG command arbiter.
// MIG_ARB_FIXED_PRIO_EN: port 0 always wins a tie and no last-grant input exists.
module mig_rr_pick (
  input  logic v0,
  input  logic v1,
`ifndef MIG_ARB_FIXED_PRIO_EN
  input  logic lp,
`endif
  output logic any_c,
  output logic win_c
);

  assign any_c = v0 | v1;

`ifdef MIG_ARB_FIXED_PRIO_EN
  assign win_c = v1 & ~v0;
`else
  // On a tie the port that was not granted last wins.
  assign win_c = v1 & (~v0 | ~lp);
`endif

endmodule

// File: rtl/mig_cmd_arb.sv
// Two-port arbiter feeding the MIG command and write-data async FIFOs.
// Build option MIG_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module mig_cmd_arb
  import mig_pkg::*;
#(
  parameter int unsigned ADRW = ADRW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic                      req0_wr,
  input  logic [LEN_W-1:0]          req0_len,
  input  logic [ADRW-1:0]           req0_adr,
  input  logic                      req0_wvalid,
  output logic                      req0_wready,
  input  logic [DW-1:0]             req0_wdata,

  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic                      req1_wr,
  input  logic [LEN_W-1:0]          req1_len,
  input  logic [ADRW-1:0]           req1_adr,
  input  logic                      req1_wvalid,
  output logic                      req1_wready,
  input  logic [DW-1:0]             req1_wdata,

  output logic                      cmd_wen,
  input  logic                      cmd_wqfull,
  output logic [ADRW+CMD_HDR_W-1:0] cmd_wdata,

  output logic                      dat_wen,
  input  logic                      dat_wqfull,
  output logic [DW-1:0]             dat_wdata,

  output logic                      busy
);

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             wr_q, wr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ADRW-1:0]  adr_q, adr_d;
  logic             any_c, win_c;
  logic             wvalid_c;

`ifndef MIG_ARB_FIXED_PRIO_EN
  logic lp_q, lp_d;
`endif

  mig_rr_pick u_pick (
    .v0    (req0_valid),
    .v1    (req1_valid),
`ifndef MIG_ARB_FIXED_PRIO_EN
    .lp    (lp_q),
`endif
    .any_c (any_c),
    .win_c (win_c)
  );

  // State and latched command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      adr_q   <= adr_d;
    end
  end

`ifndef MIG_ARB_FIXED_PRIO_EN
  // Last-granted pointer; port 1 after reset so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) lp_q <= 1'b1;
    else     lp_q <= lp_d;
  end
`endif

  // Next state and handshakes; everything is held at zero while rst is high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    wr_d        = wr_q;
    len_d       = len_q;
    adr_d       = adr_q;
`ifndef MIG_ARB_FIXED_PRIO_EN
    lp_d        = lp_q;
`endif
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    req0_wready = 1'b0;
    req1_wready = 1'b0;
    cmd_wen     = 1'b0;
    cmd_wdata   = '0;
    dat_wen     = 1'b0;
    dat_wdata   = '0;
    busy        = 1'b0;
    wvalid_c    = 1'b0;

    if (!rst) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (any_c) begin
            req0_ready = ~win_c;
            req1_ready = win_c;
            id_d       = win_c;
            wr_d       = win_c ? req1_wr  : req0_wr;
            len_d      = win_c ? req1_len : req0_len;
            adr_d      = win_c ? req1_adr : req0_adr;
            state_d    = CMD;
          end
        end

        CMD: begin
          cmd_wen                                = ~cmd_wqfull;
          cmd_wdata[ADRW-1:0]                    = adr_q;
          cmd_wdata[ADRW+CMD_LEN_OFS +: LEN_W]   = len_q;
          cmd_wdata[ADRW+CMD_WR_OFS]             = wr_q;
          cmd_wdata[ADRW+CMD_ID_OFS]             = id_q;
          if (!cmd_wqfull) begin
`ifndef MIG_ARB_FIXED_PRIO_EN
            lp_d = id_q;
`endif
            if (wr_q) begin
              state_d = WDAT;
              cnt_d   = len_q;
            end else begin
              state_d = IDLE;
            end
          end
        end

        WDAT: begin
          wvalid_c    = id_q ? req1_wvalid : req0_wvalid;
          req0_wready = ~id_q & ~dat_wqfull;
          req1_wready = id_q & ~dat_wqfull;
          dat_wen     = wvalid_c & ~dat_wqfull;
          dat_wdata   = id_q ? req1_wdata : req0_wdata;
          // The beat pushed with the counter at zero closes the burst.
          if (dat_wen) begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - LEN_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_cmd_arb.sv
// Scoreboard bench for mig_cmd_arb: queued port traffic, arbitration-order model, negedge monitor.
module tb_mig_cmd_arb;

  localparam int unsigned ADRW = 28;
  localparam int unsigned DW   = 128;
`ifdef MIG_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid, req0_ready, req0_wr, req0_wvalid, req0_wready;
  logic [1:0]      req0_len;
  logic [ADRW-1:0] req0_adr;
  logic [DW-1:0]   req0_wdata;
  logic            req1_valid, req1_ready, req1_wr, req1_wvalid, req1_wready;
  logic [1:0]      req1_len;
  logic [ADRW-1:0] req1_adr;
  logic [DW-1:0]   req1_wdata;
  logic            cmd_wen, cmd_wqfull, dat_wen, dat_wqfull, busy;
  logic [ADRW+3:0] cmd_wdata;
  logic [DW-1:0]   dat_wdata;

  always #5 clk = ~clk;

  mig_cmd_arb #(.ADRW(ADRW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr), .req0_len(req0_len),
    .req0_adr(req0_adr), .req0_wvalid(req0_wvalid), .req0_wready(req0_wready), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr), .req1_len(req1_len),
    .req1_adr(req1_adr), .req1_wvalid(req1_wvalid), .req1_wready(req1_wready), .req1_wdata(req1_wdata),
    .cmd_wen(cmd_wen), .cmd_wqfull(cmd_wqfull), .cmd_wdata(cmd_wdata),
    .dat_wen(dat_wen), .dat_wqfull(dat_wqfull), .dat_wdata(dat_wdata),
    .busy(busy)
  );

  typedef struct packed {
    logic                 wr;
    logic [1:0]           len;
    logic [ADRW-1:0]      adr;
    logic [3:0][DW-1:0]   d;
  } cmd_t;

  cmd_t            pq0[$], pq1[$];
  logic [DW-1:0]   bq0[$], bq1[$];
  logic [ADRW+3:0] exp_cmd[$];
  logic [DW-1:0]   exp_dat[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit m_lp        = 1'b1;
  bit rand_full   = 1'b0;
  bit rand_wv     = 1'b0;
  bit force_cfull = 1'b0;
  bit force_dfull = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input string info);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s at %0t", nm, info, $time);
  endtask

  function automatic logic [DW-1:0] rnd_dat();
    return DW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic cmd_t mk(input bit wr, input logic [1:0] len, input logic [ADRW-1:0] adr);
    cmd_t c;
    c.wr  = wr;
    c.len = len;
    c.adr = adr;
    for (int k = 0; k < 4; k++) c.d[k] = rnd_dat();
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(1'($urandom), 2'($urandom), ADRW'($urandom));
  endfunction

  // Reference model: both port queues are presented together; a tie goes to the
  // port not granted last (or port 0 with fixed priority), and writes stream their beats in order.
  task automatic add_phase(input cmd_t a[$], input cmd_t b[$]);
    int   i = 0;
    int   j = 0;
    bit   pick;
    cmd_t c;
    foreach (a[k]) pq0.push_back(a[k]);
    foreach (b[k]) pq1.push_back(b[k]);
    while (i < a.size() || j < b.size()) begin
      if (i < a.size() && j < b.size()) pick = FIXED_PRIO ? 1'b0 : !m_lp;
      else                              pick = (i >= a.size());
      if (pick) begin c = b[j]; j++; end
      else      begin c = a[i]; i++; end
      exp_cmd.push_back({pick, c.wr, c.len, c.adr});
      if (c.wr) for (int k = 0; k <= int'(c.len); k++) exp_dat.push_back(c.d[k]);
      m_lp = pick;
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((pq0.size() + pq1.size() + bq0.size() + bq1.size() + exp_cmd.size() + exp_dat.size()) != 0 || busy) begin
      @(negedge clk);
      t++;
      if (t > budget) begin
        fail_now("drain_timeout", $sformatf("%0d cmds and %0d beats outstanding", exp_cmd.size(), exp_dat.size()));
        break;
      end
    end
  endtask

  task automatic wait_dat(input string nm);
    int t = 0;
    @(negedge clk);
    while (!dat_wen && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 256'(dat_wen), 256'(1));
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, 256'({req0_ready, req1_ready, req0_wready, req1_wready, cmd_wen, dat_wen, busy}), 256'(0));
    chk({nm, "_cmd_wdata"}, 256'(cmd_wdata), 256'(0));
    chk({nm, "_dat_wdata"}, 256'(dat_wdata), 256'(0));
  endtask

  // Port drivers and FIFO-full generators, applied just after each rising edge.
  initial begin
    {req0_valid, req0_wr, req0_wvalid, req1_valid, req1_wr, req1_wvalid, cmd_wqfull, dat_wqfull} = '0;
    req0_len = '0; req0_adr = '0; req0_wdata = '0;
    req1_len = '0; req1_adr = '0; req1_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pq0.size() != 0) begin
        req0_valid = 1'b1; req0_wr = pq0[0].wr; req0_len = pq0[0].len; req0_adr = pq0[0].adr;
      end else begin
        req0_valid = 1'b0; req0_wr = 1'($urandom); req0_len = 2'($urandom); req0_adr = ADRW'($urandom);
      end
      if (bq0.size() != 0) begin
        req0_wvalid = !rand_wv || ($urandom % 3 != 0); req0_wdata = bq0[0];
      end else begin
        req0_wvalid = 1'($urandom); req0_wdata = rnd_dat();
      end
      if (pq1.size() != 0) begin
        req1_valid = 1'b1; req1_wr = pq1[0].wr; req1_len = pq1[0].len; req1_adr = pq1[0].adr;
      end else begin
        req1_valid = 1'b0; req1_wr = 1'($urandom); req1_len = 2'($urandom); req1_adr = ADRW'($urandom);
      end
      if (bq1.size() != 0) begin
        req1_wvalid = !rand_wv || ($urandom % 3 != 0); req1_wdata = bq1[0];
      end else begin
        req1_wvalid = 1'($urandom); req1_wdata = rnd_dat();
      end
      cmd_wqfull = rand_full ? ($urandom % 3 == 0) : force_cfull;
      dat_wqfull = rand_full ? ($urandom % 3 == 0) : force_dfull;
    end
  end

  // Port-side bookkeeping of accepted commands and beats.
  initial begin : bookkeeper
    cmd_t c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req0_ready && pq0.size() != 0) begin
          c = pq0.pop_front();
          if (c.wr) for (int k = 0; k <= int'(c.len); k++) bq0.push_back(c.d[k]);
        end
        if (req1_ready && pq1.size() != 0) begin
          c = pq1.pop_front();
          if (c.wr) for (int k = 0; k <= int'(c.len); k++) bq1.push_back(c.d[k]);
        end
        if (req0_wready && req0_wvalid) begin
          if (bq0.size() != 0) void'(bq0.pop_front());
          else fail_now("wready_no_beat0", "port 0 beat taken with none outstanding");
        end
        if (req1_wready && req1_wvalid) begin
          if (bq1.size() != 0) void'(bq1.pop_front());
          else fail_now("wready_no_beat1", "port 1 beat taken with none outstanding");
        end
      end
    end
  end

  // Monitor: compares every FIFO push against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req0_ready || req1_ready) begin
          chk("ready_onehot", 256'(req0_ready & req1_ready), 256'(0));
          chk("ready_without_valid", 256'({req1_ready & ~req1_valid, req0_ready & ~req0_valid}), 256'(0));
        end
        if (cmd_wen) begin
          chk("cmd_wen_while_full", 256'(cmd_wqfull), 256'(0));
          if (exp_cmd.size() == 0) fail_now("cmd_extra", $sformatf("unexpected push %0h", cmd_wdata));
          else chk("cmd_word", 256'(cmd_wdata), 256'(exp_cmd.pop_front()));
        end
        if (dat_wen) begin
          chk("dat_wen_while_full", 256'(dat_wqfull), 256'(0));
          chk("dat_wen_handshake", 256'((req0_wvalid & req0_wready) | (req1_wvalid & req1_wready)), 256'(1));
          if (exp_dat.size() == 0) fail_now("dat_extra", $sformatf("unexpected beat %0h", dat_wdata));
          else chk("dat_word", 256'(dat_wdata), 256'(exp_dat.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t qa[$], qb[$];

    // Reset holds every output at zero even with a request pending.
    repeat (2) @(negedge clk);
    qa.push_back(mk(1'b0, 2'd1, 28'h0ABCDEF));
    add_phase(qa, qb);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;
    drain(100);

    // Single read latency.
    qa.delete(); qb.delete();
    qa.push_back(mk(1'b0, 2'd0, 28'h100));
    add_phase(qa, qb);
    @(negedge clk);
    chk("rd_ready_c0", 256'({req0_ready, req1_ready, busy}), 256'(3'b100));
    @(negedge clk);
    chk("rd_cmd_c1", 256'({cmd_wen, busy}), 256'(2'b11));
    chk("rd_cmd_word_c1", 256'(cmd_wdata), 256'(32'h0000_0100));
    @(negedge clk);
    chk("rd_idle_c2", 256'(busy), 256'(0));
    drain(100);

    // Port 1 four-beat write with continuous wvalid.
    qa.delete(); qb.delete();
    qb.push_back(mk(1'b1, 2'd3, 28'h0001230));
    add_phase(qa, qb);
    wait_dat("wr_first_beat");
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("wr_consecutive_beat", 256'(dat_wen), 256'(1));
    end
    @(negedge clk);
    chk("wr_idle_after_burst", 256'({busy, dat_wen}), 256'(0));
    drain(100);

    // Contention: reads queued on both ports.
    qa.delete(); qb.delete();
    for (int k = 0; k < 4; k++) begin
      qa.push_back(mk(1'b0, 2'($urandom), ADRW'(32'h1000 + k)));
      qb.push_back(mk(1'b0, 2'($urandom), ADRW'(32'h2000 + k)));
    end
    add_phase(qa, qb);
    drain(200);

    // Command FIFO full for five CMD cycles.
    qa.delete(); qb.delete();
    force_cfull = 1'b1;
    qa.push_back(mk(1'b0, 2'd2, 28'h0000440));
    add_phase(qa, qb);
    @(negedge clk);
    chk("bp_grant", 256'(req0_ready), 256'(1));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("bp_no_push", 256'({cmd_wen, busy}), 256'(2'b01));
    end
    force_cfull = 1'b0;
    @(negedge clk);
    chk("bp_push_c6", 256'(cmd_wen), 256'(1));
    drain(100);

    // Reset on the second beat of a four-beat write abandons the burst.
    qa.delete(); qb.delete();
    qb.push_back(mk(1'b1, 2'd3, 28'h0007700));
    add_phase(qa, qb);
    wait_dat("rst_burst_first_beat");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_quiet("rst_mid_burst");
    pq0.delete(); pq1.delete(); bq0.delete(); bq1.delete();
    exp_cmd.delete(); exp_dat.delete();
    m_lp = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_recover_idle", 256'({busy, cmd_wen, dat_wen}), 256'(0));
    qa.delete(); qb.delete();
    qa.push_back(mk(1'b0, 2'd0, 28'h0000A00));
    qb.push_back(mk(1'b0, 2'd0, 28'h0000B00));
    add_phase(qa, qb);
    drain(100);

    // Randomized traffic with FIFO backpressure and wvalid gaps.
    for (int p = 0; p < 20; p++) begin
      qa.delete(); qb.delete();
      rand_full = 1'($urandom);
      rand_wv   = 1'($urandom);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) qa.push_back(rnd_cmd());
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) qb.push_back(rnd_cmd());
      add_phase(qa, qb);
      drain(3000);
    end
    rand_full = 1'b0;
    rand_wv   = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mig_cmd_arb.md
MIG_CMD_ARB -- requirements
Module: mig_cmd_arb

Interface
REQ-001 Parameter ADRW, default 28, gives the command address width in bits.
REQ-002 Parameter DW, default 128, gives the write data beat width in bits.
REQ-003 clk  input  1  the single clock. Reset is synchronous and active-high; all state changes on the rising edge of clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 reqN_valid  input  1  port N (N=0,1) has a command pending.
REQ-006 reqN_ready  output  1  port N command accepted this cycle.
REQ-007 reqN_wr  input  1  1=write, 0=read.
REQ-008 reqN_len  input  2  burst beats minus 1.
REQ-009 reqN_adr  input  ADRW  burst start address.
REQ-010 reqN_wvalid  input  1  port N write beat valid.
REQ-011 reqN_wready  output  1  port N write beat accepted this cycle.
REQ-012 reqN_wdata  input  DW  port N write beat data.
REQ-013 cmd_wen  output  1  push to command afifo.
REQ-014 cmd_wqfull  input  1  command afifo full.
REQ-015 cmd_wdata  output  ADRW+4  pushed command: {id, wr, len[1:0], adr}.
REQ-016 dat_wen  output  1  push to write-data afifo.
REQ-017 dat_wqfull  input  1  write-data afifo full.
REQ-018 dat_wdata  output  DW  pushed write beat.
REQ-019 busy  output  1  state is not IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, CMD, WDAT.
REQ-021 In IDLE with any reqN_valid, the block SHALL select a winner, assert that port's reqN_ready combinationally in the same cycle, latch id/wr/len/adr, and go to CMD.
REQ-022 Round-robin: with both ports valid, the winner SHALL be the port other than the last-granted pointer lp. lp resets to 1, so port 0 wins first.
REQ-023 In CMD, cmd_wen SHALL equal ~cmd_wqfull, driving the latched fields on cmd_wdata. On push, lp SHALL take the latched id.
REQ-024 After the CMD push, the next state SHALL be WDAT for a write (beat counter loaded with len) or IDLE for a read.
REQ-025 In WDAT, the granted port's wready SHALL equal ~dat_wqfull.
REQ-026 In WDAT, dat_wen SHALL equal wvalid & ~dat_wqfull, and dat_wdata SHALL equal the granted port's wdata.
REQ-027 Each WDAT beat SHALL decrement the counter. The beat pushed at counter 0 SHALL return the FSM to IDLE.
REQ-028 The ungranted port's ready and wready SHALL be 0 at all times. No ready or wready SHALL be asserted outside the states named above.
REQ-029 cmd_wqfull or dat_wqfull held high SHALL stall the FSM indefinitely with no push, no lost beat, and no grant change.
REQ-030 Minimum latency from valid to cmd_wen SHALL be 1 cycle.
REQ-031 A read SHALL return the FSM to IDLE 2 cycles after acceptance when the afifo is not full.

Reset
REQ-032 While rst is high: state=IDLE, lp=1, beat counter=0.
REQ-033 While rst is high, all ready/wready/cmd_wen/dat_wen/busy outputs SHALL be 0, and cmd_wdata/dat_wdata SHALL be 0.
REQ-034 Reset asserted mid-CMD or mid-WDAT SHALL abandon the burst with no further push. Recovery of partial bursts is the system's responsibility.

Configuration
REQ-035 Macro MIG_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win simultaneous requests, and lp is not implemented.
REQ-036 Macro MIG_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-022.

Structure
REQ-037 Shared package mig_pkg SHALL hold the FSM state encoding (IDLE=0, CMD=1, WDAT=2), the cmd_wdata field offsets, and the default ADRW/DW constants.
REQ-038 One sub-module, mig_rr_pick (2-input round-robin/fixed winner select), is natural. Everything else is flat.

Verification
REQ-039 Read: port 0 single read, adr=0x100, len=0, FIFOs empty -> req0_ready cycle 0; cmd_wen cycle 1 with cmd_wdata={0,0,0,0x100}; busy low cycle 2.
REQ-040 Write: port 1 write, len=3, wvalid always -> cmd_wen once, then 4 consecutive dat_wen with data in order, then IDLE.
REQ-041 Contention: both valid every cycle, reads only -> grants alternate 0,1,0,1. With MIG_ARB_FIXED_PRIO_EN, port 0 is granted every time.
REQ-042 Backpressure: cmd_wqfull high 5 cycles in CMD -> no cmd_wen for 5 cycles; push on cycle 6. Also toggling dat_wqfull mid-burst -> exactly len+1 beats with no duplicates.
REQ-043 Reset during burst: rst on the 2nd beat of a 4-beat write -> next cycle all outputs 0, state IDLE; the next request is served normally with port 0 winning the tie.
